coin_feeder: RTL and testbench

COIN_FEEDER -- requirements
Module: coin_feeder

---
 rtl/coin_feeder.sv | 145 ++++++++++++++
 tb/tb_coin_feeder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/coin_feeder.sv
// Coin feeder: pays out 5*amount as a burst of ten/five coin codes, tens first,
// with GAP idle cycles between coins, plus abort, dispense counting and done.
module coin_feeder #(
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [4:0] amount,
  input  logic       abort,
  input  logic       dispense,
  output logic [1:0] coin,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [3:0] vend_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP_WAIT, FINISH} state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_FIVE = 2'b01;
  localparam logic [1:0] COIN_TEN  = 2'b10;
  localparam logic [2:0] GAP_M1    = 3'(GAP > 0 ? GAP - 1 : 0);

  state_t     state_q, state_d;
  logic [3:0] n10_q, n10_d;
  logic       n5_q, n5_d;
  logic [2:0] gap_q, gap_d;
  logic [1:0] coin_q, coin_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       aborted_q, aborted_d;
  logic [3:0] vend_q, vend_d;

  // Coin source: the fresh amount on the accept edge, the latched counts after.
  logic [3:0] src10;
  logic       src5;
  logic [1:0] nx_coin;
  logic [3:0] nx_n10;
  logic       nx_n5;
  logic       more;

  always_comb begin
    src10   = (state_q == IDLE) ? amount[4:1] : n10_q;
    src5    = (state_q == IDLE) ? amount[0]   : n5_q;
    nx_coin = (src10 != 4'd0) ? COIN_TEN : COIN_FIVE;
    nx_n10  = (src10 != 4'd0) ? src10 - 4'd1 : src10;
    nx_n5   = (src10 != 4'd0) ? src5 : 1'b0;
    more    = (n10_q != 4'd0) || n5_q;
  end

  always_comb begin
    state_d   = state_q;
    n10_d     = n10_q;
    n5_d      = n5_q;
    gap_d     = gap_q;
    coin_d    = COIN_NONE;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    vend_d    = vend_q;

    if (busy_q && dispense && vend_q != 4'hF)
      vend_d = vend_q + 4'd1;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          vend_d = 4'd0;
          busy_d = 1'b1;
          if (amount == 5'd0) begin
            n10_d   = 4'd0;
            n5_d    = 1'b0;
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            coin_d  = nx_coin;
            n10_d   = nx_n10;
            n5_d    = nx_n5;
            state_d = SEND;
          end
        end
      end
      SEND, GAP_WAIT: begin
        if (abort) begin
          n10_d     = 4'd0;
          n5_d      = 1'b0;
          state_d   = FINISH;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (state_q == GAP_WAIT && gap_q != 3'd0) begin
          gap_d = gap_q - 3'd1;
        end else if (state_q == SEND && !more) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else if (state_q == SEND && GAP > 0) begin
          gap_d   = GAP_M1;
          state_d = GAP_WAIT;
        end else begin
          coin_d  = nx_coin;
          n10_d   = nx_n10;
          n5_d    = nx_n5;
          state_d = SEND;
        end
      end
      FINISH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      n10_q     <= 4'd0;
      n5_q      <= 1'b0;
      gap_q     <= 3'd0;
      coin_q    <= COIN_NONE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      vend_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      n10_q     <= n10_d;
      n5_q      <= n5_d;
      gap_q     <= gap_d;
      coin_q    <= coin_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      vend_q    <= vend_d;
    end
  end

  assign coin       = coin_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign vend_count = vend_q;

endmodule

// File: tb/tb_coin_feeder.sv
// Drives three coin_feeder instances (GAP=0,1,2) with shared stimulus and
// compares each cycle against a coin-list model built from amount and GAP.
module tb_coin_feeder;
  localparam int NG = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [4:0] amount = 5'd0;
  logic abort = 1'b0;
  logic dispense = 1'b0;

  logic [NG-1:0][1:0] coin_o;
  logic [NG-1:0]      busy_o, done_o, ab_o;
  logic [NG-1:0][3:0] vend_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NG; g++) begin : g_dut
    coin_feeder #(.GAP(g)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .amount(amount),
      .abort(abort), .dispense(dispense), .coin(coin_o[g]), .busy(busy_o[g]),
      .done(done_o[g]), .aborted(ab_o[g]), .vend_count(vend_o[g])
    );
  end

  task automatic check_idle_zero(input string tag);
    for (int g = 0; g < NG; g++) begin
      checks++;
      if ({coin_o[g], busy_o[g], done_o[g], ab_o[g], vend_o[g]} !== 9'd0) begin
        errors++;
        $display("FAIL %s gap=%0d coin=%b busy=%b done=%b ab=%b vend=%0d required all zero",
                 tag, g, coin_o[g], busy_o[g], done_o[g], ab_o[g], vend_o[g]);
      end
    end
  endtask

  // One transaction: start at the edge after this call's first negedge.
  // abort_k/disp refer to cycles t+k after the accept edge t.
  task automatic run_txn(input logic [4:0] amt, input int abort_k,
                         input logic [63:0] disp, input bit spur);
    logic [1:0] seq [NG][64];
    int len[NG], endc[NG], vcnt[NG], sum[NG];
    bit ab[NG];
    int n10, n5, coins, kmax, minend, p;
    logic [1:0] e_coin;
    logic e_busy, e_done, e_ab;
    n10 = int'(amt[4:1]);
    n5  = int'(amt[0]);
    coins = n10 + n5;
    kmax = 0;
    minend = 1000;
    for (int g = 0; g < NG; g++) begin
      p = 0;
      for (int j = 0; j < coins; j++) begin
        seq[g][p++] = (j < n10) ? 2'b10 : 2'b01;
        if (j < coins - 1) for (int z = 0; z < g; z++) seq[g][p++] = 2'b00;
      end
      len[g]  = p;
      ab[g]   = (abort_k >= 1) && (abort_k <= len[g]);
      endc[g] = ab[g] ? abort_k : len[g];
      if (endc[g] + 2 > kmax) kmax = endc[g] + 2;
      if (endc[g] < minend) minend = endc[g];
      vcnt[g] = 0;
      sum[g]  = 0;
    end
    @(negedge clk);
    start = 1'b1; amount = amt; abort = 1'b0; dispense = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      for (int g = 0; g < NG; g++) begin
        e_coin = (k <= endc[g]) ? seq[g][k-1] : 2'b00;
        e_busy = (k <= endc[g] + 1);
        e_done = (k == endc[g] + 1);
        e_ab   = e_done && ab[g];
        checks++;
        if (coin_o[g] !== e_coin || busy_o[g] !== e_busy || done_o[g] !== e_done ||
            ab_o[g] !== e_ab || vend_o[g] !== 4'(vcnt[g])) begin
          errors++;
          $display("FAIL txn amt=%0d gap=%0d k=%0d got coin=%b busy=%b done=%b ab=%b vend=%0d want coin=%b busy=%b done=%b ab=%b vend=%0d",
                   amt, g, k, coin_o[g], busy_o[g], done_o[g], ab_o[g], vend_o[g],
                   e_coin, e_busy, e_done, e_ab, vcnt[g]);
        end
        if (coin_o[g] == 2'b10) sum[g] += 10;
        if (coin_o[g] == 2'b01) sum[g] += 5;
        if (disp[k] && k <= endc[g] + 1 && vcnt[g] < 15) vcnt[g]++;
      end
      start    = spur && (k <= minend + 1);
      amount   = spur ? 5'($urandom_range(0, 31)) : amt;
      abort    = (k == abort_k);
      dispense = disp[k];
    end
    for (int g = 0; g < NG; g++) begin
      if (!ab[g]) begin
        checks++;
        if (sum[g] != 5 * int'(amt)) begin
          errors++;
          $display("FAIL total amt=%0d gap=%0d paid=%0d want=%0d", amt, g, sum[g], 5 * int'(amt));
        end
      end
    end
    start = 1'b0; abort = 1'b0; dispense = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1 check_idle_zero("reset");
    repeat (2) @(negedge clk);
    check_idle_zero("reset_hold");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle_zero("after_reset");
  endtask

  task automatic test_gap_basic();
    run_txn(5'd3, 0, 64'd0, 1'b0);
    run_txn(5'd1, 0, 64'd0, 1'b0);
    run_txn(5'd8, 0, 64'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn(5'd5, 0, 64'd0, 1'b1);
    run_txn(5'd0, 0, 64'd0, 1'b1);
    run_txn(5'd10, 0, 64'd0, 1'b1);
  endtask

  task automatic test_abort();
    run_txn(5'd6, 4, 64'd0, 1'b0);
    run_txn(5'd3, 2, 64'd0, 1'b0);
    run_txn(5'd7, 1, 64'd0, 1'b0);
    run_txn(5'd2, 2, 64'd0, 1'b0);
  endtask

  task automatic test_vend();
    run_txn(5'd3, 0, 64'h18, 1'b0);
    run_txn(5'd31, 0, {64{1'b1}}, 1'b0);
    run_txn(5'd0, 0, {64{1'b1}}, 1'b0);
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    start = 1'b1; amount = 5'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_idle_zero("async_reset");
    @(negedge clk);
    check_idle_zero("reset_mid");
    reset_n = 1'b1;
    run_txn(5'd1, 0, 64'd0, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] d;
    for (int i = 0; i < 25; i++) begin
      d = {$urandom, $urandom};
      run_txn(5'($urandom_range(0, 31)),
              ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 50)) : 0,
              d, $urandom_range(0, 1) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_gap_basic();
    test_back_to_back();
    test_abort();
    test_vend();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
